sigma_delta_scan_ctrl: RTL and testbench

- Multi-channel scan controller that time-shares one sigma_delta_counter instance between NUM_CHANNELS modulator bitstreams.
- Selects a channel, resets the counter, discards settling windows, and captures one conversion result per channel.
- Delivers each result on a valid/ready stream, tagged with its channel number.
- Sits between the modulator front-ends and the readout/register interface.

---
 rtl/sigma_delta_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_sigma_delta_scan_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_scan_ctrl.sv
// rtl/sigma_delta_scan_ctrl.sv - time-shares one sigma-delta counter across several modulator channels
`timescale 1ns/1ps
module sigma_delta_scan_ctrl #(
  parameter int NUM_CHANNELS      = 4,
  parameter int NUMBER_OF_SAMPLES = 1000,
  parameter int SETTLE_WINDOWS    = 1,
  localparam int CW = $clog2(NUMBER_OF_SAMPLES + 1),
  localparam int SW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    abort,
  input  logic [NUM_CHANNELS-1:0] chan_mask,
  input  logic [NUM_CHANNELS-1:0] pulse_in,
  output logic [NUM_CHANNELS-1:0] mod_en,
  output logic                    cnt_rst,
  output logic                    cnt_pulse,
  input  logic [CW-1:0]           cnt_ones,
  input  logic                    cnt_ready,
  output logic [CW-1:0]           result_data,
  output logic [SW-1:0]           result_chan,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {S_IDLE, S_SWITCH, S_SETTLE, S_MEASURE, S_OUTPUT} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                    cont_q, cont_d;
  logic [1:0]              settle_q, settle_d;
  logic [CW-1:0]           rdata_q, rdata_d;
  logic [SW-1:0]           rchan_q, rchan_d;
  logic                    done_q, done_d;

  logic [SW-1:0] start_sel, first_sel, next_sel;
  logic          has_next;

  // Descending scan so the last hit is the lowest qualifying channel.
  always_comb begin
    start_sel = '0;
    first_sel = '0;
    next_sel  = '0;
    has_next  = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (chan_mask[i]) start_sel = SW'(i);
      if (mask_q[i]) first_sel = SW'(i);
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_sel = SW'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mask_d   = mask_q;
    cont_d   = cont_q;
    settle_d = settle_q;
    rdata_d  = rdata_q;
    rchan_d  = rchan_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (|chan_mask)) begin
          mask_d  = chan_mask;
          cont_d  = cont;
          sel_d   = start_sel;
          state_d = S_SWITCH;
        end
      end
      S_SWITCH: begin
        settle_d = '0;
        state_d  = (SETTLE_WINDOWS > 0) ? S_SETTLE : S_MEASURE;
      end
      S_SETTLE: begin
        if (cnt_ready) begin
          if (({1'b0, settle_q} + 3'd1) == 3'(SETTLE_WINDOWS)) state_d = S_MEASURE;
          else settle_d = settle_q + 2'd1;
        end
      end
      S_MEASURE: begin
        if (cnt_ready) begin
          rdata_d = cnt_ones;
          rchan_d = sel_q;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (result_ready) begin
          if (has_next) begin
            sel_d   = next_sel;
            state_d = S_SWITCH;
          end else if (cont_q) begin
            sel_d   = first_sel;
            state_d = S_SWITCH;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort looks exactly like a reset to everything downstream.
    if (abort) begin
      state_d  = S_IDLE;
      sel_d    = '0;
      settle_d = '0;
      rdata_d  = '0;
      rchan_d  = '0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      mask_q   <= '0;
      cont_q   <= 1'b0;
      settle_q <= '0;
      rdata_q  <= '0;
      rchan_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      cont_q   <= cont_d;
      settle_q <= settle_d;
      rdata_q  <= rdata_d;
      rchan_q  <= rchan_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    mod_en = '0;
    if (state_q != S_IDLE) mod_en[sel_q] = 1'b1;
  end

  assign cnt_rst      = (state_q == S_IDLE) || (state_q == S_SWITCH) || (state_q == S_OUTPUT);
  assign cnt_pulse    = pulse_in[sel_q];
  assign result_data  = rdata_q;
  assign result_chan  = rchan_q;
  assign result_valid = (state_q == S_OUTPUT);
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_sigma_delta_scan_ctrl.sv
// tb/tb_sigma_delta_scan_ctrl.sv - scoreboard bench for the scan controller with behavioural counters
`timescale 1ns/1ps
module tb_sigma_delta_scan_ctrl;
  localparam int NC = 4;
  localparam int N  = 8;
  localparam int CW = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, cont, abort, result_ready;
  logic [NC-1:0] chan_mask, pstat, pulse_in;
  logic          tog = 1'b0;
  always @(negedge clk) tog = ~tog;
  assign pulse_in = pstat | {2'b00, tog, 1'b0};

  logic [NC-1:0] mod_en0, mod_en1;
  logic          cnt_rst0, cnt_rst1, cnt_pulse0, cnt_pulse1, cnt_ready0, cnt_ready1;
  logic [CW-1:0] cnt_ones0, cnt_ones1, result_data0, result_data1;
  logic [SW-1:0] result_chan0, result_chan1;
  logic          result_valid0, result_valid1, busy0, busy1, done0, done1;

  sigma_delta_scan_ctrl #(.NUM_CHANNELS(NC), .NUMBER_OF_SAMPLES(N), .SETTLE_WINDOWS(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort), .chan_mask(chan_mask),
    .pulse_in(pulse_in), .mod_en(mod_en0), .cnt_rst(cnt_rst0), .cnt_pulse(cnt_pulse0),
    .cnt_ones(cnt_ones0), .cnt_ready(cnt_ready0), .result_data(result_data0),
    .result_chan(result_chan0), .result_valid(result_valid0), .result_ready(result_ready),
    .busy(busy0), .done(done0));

  sigma_delta_scan_ctrl #(.NUM_CHANNELS(NC), .NUMBER_OF_SAMPLES(N), .SETTLE_WINDOWS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort), .chan_mask(chan_mask),
    .pulse_in(pulse_in), .mod_en(mod_en1), .cnt_rst(cnt_rst1), .cnt_pulse(cnt_pulse1),
    .cnt_ones(cnt_ones1), .cnt_ready(cnt_ready1), .result_data(result_data1),
    .result_chan(result_chan1), .result_valid(result_valid1), .result_ready(result_ready),
    .busy(busy1), .done(done1));

  // Behavioural windowed counters plus run-length of cnt_rst=0 (equals j while sampled mid-cycle).
  int cyc0 = 0, acc0 = 0, run0 = 0, cyc1 = 0, acc1 = 0, run1 = 0;
  always @(posedge clk) begin
    run0 <= cnt_rst0 ? 0 : run0 + 1;
    if (cnt_rst0) begin
      cyc0 <= 0; acc0 <= 0; cnt_ready0 <= 1'b0; cnt_ones0 <= '0;
    end else if (cyc0 == N - 1) begin
      cyc0 <= 0; acc0 <= 0; cnt_ready0 <= 1'b1; cnt_ones0 <= CW'(acc0 + int'(cnt_pulse0));
    end else begin
      cyc0 <= cyc0 + 1; acc0 <= acc0 + int'(cnt_pulse0); cnt_ready0 <= 1'b0;
    end
  end
  always @(posedge clk) begin
    run1 <= cnt_rst1 ? 0 : run1 + 1;
    if (cnt_rst1) begin
      cyc1 <= 0; acc1 <= 0; cnt_ready1 <= 1'b0; cnt_ones1 <= '0;
    end else if (cyc1 == N - 1) begin
      cyc1 <= 0; acc1 <= 0; cnt_ready1 <= 1'b1; cnt_ones1 <= CW'(acc1 + int'(cnt_pulse1));
    end else begin
      cyc1 <= cyc1 + 1; acc1 <= acc1 + int'(cnt_pulse1); cnt_ready1 <= 1'b0;
    end
  end

  typedef struct packed {
    logic [SW-1:0] chan;
    logic [CW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int fails  = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [SW-1:0] c, input logic [CW-1:0] d);
    exp_t e;
    e.chan = c;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
    chan_mask = '0; pstat = '0; result_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic start_pass(input logic [NC-1:0] m, input logic c);
    start = 1'b1; chan_mask = m; cont = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_result1(input logic [NC-1:0] exp_mod, input int exp_run, input string name);
    int   t;
    exp_t e;
    t = 0;
    while (!result_valid1 && t < 400) begin
      tick();
      t++;
    end
    checks++;
    if (!result_valid1) begin
      fails++;
      $display("FAIL %s_timeout: result_valid=%b required 1", name, result_valid1);
    end else begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL %s_unexpected: got chan=%0d data=%0d, no result expected", name, result_chan1, result_data1);
      end else begin
        e = sb.pop_front();
        if ({result_chan1, result_data1} !== {e.chan, e.data}) begin
          fails++;
          $display("FAIL %s_result: got chan=%0d data=%0d required chan=%0d data=%0d",
                   name, result_chan1, result_data1, e.chan, e.data);
        end
      end
      checks++;
      if (mod_en1 !== exp_mod) begin
        fails++;
        $display("FAIL %s_mod_en: got %b required %b", name, mod_en1, exp_mod);
      end
      checks++;
      if (run1 !== exp_run) begin
        fails++;
        $display("FAIL %s_latency: got j=%0d required j=%0d", name, run1, exp_run);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mod_en1, cnt_rst1, result_valid1, busy1, done1, result_data1, result_chan1} !== {4'b0, 1'b1, 3'b0, 4'b0, 2'b0}) begin
      fails++;
      $display("FAIL reset_dut1: got %b required %b",
               {mod_en1, cnt_rst1, result_valid1, busy1, done1, result_data1, result_chan1}, {4'b0, 1'b1, 3'b0, 4'b0, 2'b0});
    end
    checks++;
    if ({mod_en0, cnt_rst0, result_valid0, busy0, done0, result_data0, result_chan0} !== {4'b0, 1'b1, 3'b0, 4'b0, 2'b0}) begin
      fails++;
      $display("FAIL reset_dut0: got %b required %b",
               {mod_en0, cnt_rst0, result_valid0, busy0, done0, result_data0, result_chan0}, {4'b0, 1'b1, 3'b0, 4'b0, 2'b0});
    end
  endtask

  task automatic test_single();
    int t;
    do_reset();
    pstat = 4'b0001;
    start_pass(4'b0001, 1'b0);
    t = 0;
    while (!result_valid0 && t < 200) begin
      tick();
      t++;
    end
    checks++;
    if ({result_valid0, result_chan0, result_data0, mod_en0} !== {1'b1, 2'd0, 4'd8, 4'b0001}) begin
      fails++;
      $display("FAIL single_result: got valid=%b chan=%0d data=%0d mod_en=%b required 1/0/8/0001",
               result_valid0, result_chan0, result_data0, mod_en0);
    end
    checks++;
    if (run0 !== 9) begin
      fails++;
      $display("FAIL single_latency: got j=%0d required j=9", run0);
    end
    tick();
    checks++;
    if ({done0, busy0, result_valid0} !== 3'b100) begin
      fails++;
      $display("FAIL single_done: got done/busy/valid=%b required 100", {done0, busy0, result_valid0});
    end
    tick();
    checks++;
    if (done0 !== 1'b0) begin
      fails++;
      $display("FAIL single_done_width: got done=%b required 0", done0);
    end
  endtask

  task automatic test_two_chan();
    do_reset();
    push_exp(2'd1, 4'd4);
    push_exp(2'd3, 4'd0);
    start_pass(4'b1010, 1'b0);
    wait_result1(4'b0010, 17, "two_c1");
    tick();
    wait_result1(4'b1000, 17, "two_c3");
    tick();
    checks++;
    if ({done1, busy1} !== 2'b10) begin
      fails++;
      $display("FAIL two_done: got done/busy=%b required 10", {done1, busy1});
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    do_reset();
    pstat = 4'b1000;
    result_ready = 1'b0;
    push_exp(2'd1, 4'd4);
    push_exp(2'd3, 4'd8);
    start_pass(4'b1010, 1'b0);
    wait_result1(4'b0010, 17, "bp_c1");
    ok = 1'b1;
    repeat (20) begin
      tick();
      if ({result_valid1, cnt_rst1, result_chan1, result_data1} !== {1'b1, 1'b1, 2'd1, 4'd4}) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_hold: got valid=%b cnt_rst=%b chan=%0d data=%0d required held 1/1/1/4",
               result_valid1, cnt_rst1, result_chan1, result_data1);
    end
    result_ready = 1'b1;
    tick();
    wait_result1(4'b1000, 17, "bp_c3");
    tick();
    checks++;
    if (done1 !== 1'b1) begin
      fails++;
      $display("FAIL bp_done: got done=%b required 1", done1);
    end
  endtask

  task automatic test_cont_abort();
    int   t;
    logic ok;
    do_reset();
    pstat = 4'b0001;
    for (int k = 0; k < 4; k++) push_exp((k % 2 == 0) ? 2'd0 : 2'd2, (k % 2 == 0) ? 4'd8 : 4'd0);
    start_pass(4'b0101, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_result1((k % 2 == 0) ? 4'b0001 : 4'b0100, 17, "cont");
      tick();
    end
    t = 0;
    while (run1 != 12 && t < 100) begin
      tick();
      t++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy1, result_valid1, mod_en1, cnt_rst1, done1} !== {2'b00, 4'b0000, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL abort_state: got busy=%b valid=%b mod_en=%b cnt_rst=%b done=%b required 0/0/0000/1/0",
               busy1, result_valid1, mod_en1, cnt_rst1, done1);
    end
    ok = 1'b1;
    repeat (30) begin
      tick();
      if (result_valid1 || done1 || busy1) ok = 1'b0;
    end
    checks++;
    if (!ok || sb.size() != 0) begin
      fails++;
      $display("FAIL abort_quiet: got quiet=%b pending=%0d required quiet=1 pending=0", ok, sb.size());
    end
  endtask

  task automatic test_mask_zero_and_busy();
    logic ok;
    do_reset();
    start_pass(4'b0000, 1'b0);
    ok = 1'b1;
    repeat (5) begin
      if (busy1 || !cnt_rst1) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL mask_zero: got busy=%b cnt_rst=%b required 0/1", busy1, cnt_rst1);
    end
    pstat = 4'b1000;
    push_exp(2'd1, 4'd4);
    push_exp(2'd3, 4'd8);
    start_pass(4'b1010, 1'b0);
    repeat (3) tick();
    start_pass(4'b0101, 1'b1);
    wait_result1(4'b0010, 17, "busy_c1");
    tick();
    wait_result1(4'b1000, 17, "busy_c3");
    tick();
    checks++;
    if (done1 !== 1'b1) begin
      fails++;
      $display("FAIL busy_done: got done=%b required 1", done1);
    end
    ok = 1'b1;
    repeat (40) begin
      tick();
      if (busy1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL busy_ignored_start: got busy=1 after pass, required 0");
    end
  endtask

  task automatic test_rst_output();
    do_reset();
    pstat = 4'b0001;
    result_ready = 1'b0;
    push_exp(2'd0, 4'd8);
    start_pass(4'b0001, 1'b0);
    wait_result1(4'b0001, 17, "rst_c0");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({result_valid1, cnt_rst1, mod_en1, busy1, done1} !== {1'b0, 1'b1, 4'b0000, 2'b00}) begin
      fails++;
      $display("FAIL rst_output: got valid=%b cnt_rst=%b mod_en=%b busy=%b done=%b required 0/1/0000/0/0",
               result_valid1, cnt_rst1, mod_en1, busy1, done1);
    end
    pstat = 4'b0100;
    result_ready = 1'b1;
    push_exp(2'd2, 4'd8);
    start_pass(4'b0100, 1'b0);
    wait_result1(4'b0100, 17, "rst_restart");
    tick();
    checks++;
    if (done1 !== 1'b1) begin
      fails++;
      $display("FAIL rst_restart_done: got done=%b required 1", done1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_chan();
    test_backpressure();
    test_cont_abort();
    test_mask_zero_and_busy();
    test_rst_output();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
